duty_meas_ctrl: RTL and testbench
=================================

# duty_meas_ctrl

Sequencer for the oscilloscope duty-cycle measurement engine. It scans the incoming sample stream to find the signal's high and low levels. It then hands those levels to the duty engine, issues start pulses and collects the engine's results. It averages a fixed number of results into one reported duty value, and reports a no-signal condition when the swing is too small or the engine stalls. It sits between the ADC sample path and the duty engine, feeding the measurement display.

## Interface
- SCAN_LEN, 1024: samples examined per level scan, 2..65536
- MIN_SWING, 16: minimum max−min swing (codes) accepted as a valid signal
- TIMEOUT, 65535: cycles allowed in WAIT before abort, ≥2
- AVG_LOG2, 2: log2 of engine results averaged per reported value, 0..4
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  continuous measurement while high
- wave_in  in  8  unsigned ADC sample
- sample_vld  in  1  wave_in valid strobe
- eng_start  out  1  one-cycle start pulse to duty engine
- eng_high  out  8  detected high level, stable from CHECK until next CHECK
- eng_low  out  8  detected low level, same stability as eng_high
- eng_done  in  1  engine result strobe
- eng_duty  in  8  engine result, percent
- duty  out  8  averaged duty, percent 0..100
- duty_vld  out  1  one-cycle pulse, duty updated
- no_signal  out  1  level flag: last attempt failed (low swing or timeout)

## Operation
- All outputs are registered. Reset values: eng_start=0, eng_high=0, eng_low=0, duty=0, duty_vld=0, no_signal=0. Internal state: IDLE, max=0, min=255, counters 0, accumulator 0.
- States: IDLE, SCAN, CHECK, START, WAIT, OUTPUT.
- IDLE: clears max=0, min=255, scan count, result count and accumulator. Goes to SCAN if enable=1.
- SCAN: on each sample_vld, max=max(max,wave_in) and min=min(min,wave_in), and the count increments. After the SCAN_LEN-th valid sample is absorbed, the next state is CHECK. Samples without sample_vld are ignored.
- CHECK (1 cycle): swing = max−min, 8-bit, never negative.
  - If swing < MIN_SWING: no_signal=1, go to IDLE.
  - Otherwise: eng_high=max, eng_low=min, go to START.
- START (1 cycle): eng_start=1 for this cycle only, WAIT timer cleared, go to WAIT.
- WAIT:
  - Timer increments each cycle.
  - On eng_done: the value min(eng_duty,100) is added to the accumulator (width 8+AVG_LOG2, no overflow possible) and the result count increments.
  - If the count now equals 2^AVG_LOG2, go to OUTPUT; otherwise go to START.
  - If the timer reaches TIMEOUT−1 without eng_done: no_signal=1, discard the accumulator, go to IDLE.
  - eng_done in the same cycle as timeout: eng_done wins.
- OUTPUT (1 cycle): duty = (acc + 2^(AVG_LOG2−1)) >> AVG_LOG2, round-half-up; for AVG_LOG2=0, duty=acc. Also duty_vld=1 and no_signal=0, then go to IDLE. IDLE re-arms automatically if enable is still 1.
- enable=0 in any state except IDLE: next state is IDLE.
  - No eng_start and no duty_vld are issued afterwards.
  - duty, eng_high, eng_low and no_signal keep their values.
  - A partial accumulation is discarded.
- eng_done outside WAIT is ignored.
- duty holds its last value between updates.

## Timing
- eng_start is high exactly 1 cycle, in the cycle after CHECK or after the accepting eng_done cycle.
- First eng_start comes 2 cycles after the SCAN_LEN-th sample_vld cycle.
- duty_vld is asserted 1 cycle after the accepting eng_done (OUTPUT cycle). duty is valid in the same cycle and held afterwards.
- Timeout abort: no_signal rises TIMEOUT cycles after the eng_start pulse.
- Minimum gap from duty_vld to the next eng_start is SCAN_LEN samples + 3 cycles, since each report triggers a fresh level scan.
- Asynchronous reset mid-operation forces all reset values immediately. No eng_start pulse completes after rst_n falls.

## Test plan
- Square wave 0/200, 25% high, SCAN_LEN=64, AVG_LOG2=2, engine model returns 25,25,26,26 → eng_high=200, eng_low=0, exactly 4 eng_start pulses, duty=26 with one duty_vld, no_signal=0.
- Constant wave_in=128 for 64 samples → CHECK fails, no_signal=1, eng_start never pulses, scan restarts while enable=1.
- Engine never asserts eng_done, TIMEOUT=100 → no_signal=1 exactly 100 cycles after eng_start, no duty_vld, duty unchanged.
- eng_duty=255 on all results → clamped, duty=100.
- enable dropped during WAIT after 2 results → IDLE next cycle, no further eng_start or duty_vld. Re-enable starts a fresh scan and a fresh accumulation of 4.
- eng_done coincident with the timeout cycle → result accepted, no_signal stays 0. rst_n pulsed low mid-SCAN → all outputs 0 at once.

Source files
------------

// File: rtl/duty_meas_if.sv
// Signal bundle between the duty-measurement sequencer, the ADC sample path,
// the duty engine and the measurement display.
interface duty_meas_if;
    logic       enable;
    logic [7:0] wave_in;
    logic       sample_vld;
    logic       eng_start;
    logic [7:0] eng_high;
    logic [7:0] eng_low;
    logic       eng_done;
    logic [7:0] eng_duty;
    logic [7:0] duty;
    logic       duty_vld;
    logic       no_signal;

    modport master (
        input  enable, wave_in, sample_vld, eng_done, eng_duty,
        output eng_start, eng_high, eng_low, duty, duty_vld, no_signal
    );

    modport slave (
        output enable, wave_in, sample_vld, eng_done, eng_duty,
        input  eng_start, eng_high, eng_low, duty, duty_vld, no_signal
    );
endinterface

// File: rtl/duty_meas_ctrl.sv
// Duty-cycle measurement sequencer: scans levels, drives the duty engine,
// averages 2^AVG_LOG2 engine results and flags missing or stalled signals.
module duty_meas_ctrl #(
    parameter int SCAN_LEN  = 1024,
    parameter int MIN_SWING = 16,
    parameter int TIMEOUT   = 65535,
    parameter int AVG_LOG2  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    duty_meas_if.master bus
);

    localparam int SCAN_W = $clog2(SCAN_LEN + 1);
    localparam int TMR_W  = $clog2(TIMEOUT + 1);
    localparam int RES_W  = AVG_LOG2 + 1;
    localparam int ACC_W  = 8 + AVG_LOG2;
    localparam int N_RES  = 1 << AVG_LOG2;
    localparam int HALF   = (1 << AVG_LOG2) >> 1;

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_LEN - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
    localparam logic [RES_W-1:0]  RES_LAST  = RES_W'(N_RES - 1);
    localparam logic [RES_W-1:0]  RES_ONE   = RES_W'(1);
    localparam logic [SCAN_W-1:0] SCAN_ONE  = SCAN_W'(1);
    localparam logic [ACC_W-1:0]  ACC_HALF  = ACC_W'(HALF);
    localparam logic [7:0]        SWING_MIN = 8'(MIN_SWING);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SCAN   = 3'd1,
        S_CHECK  = 3'd2,
        S_START  = 3'd3,
        S_WAIT   = 3'd4,
        S_OUTPUT = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         max_q, max_d, min_q, min_d;
    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [RES_W-1:0]   res_cnt_q, res_cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               eng_start_q, eng_start_d;
    logic [7:0]         eng_high_q, eng_high_d;
    logic [7:0]         eng_low_q, eng_low_d;
    logic [7:0]         duty_q, duty_d;
    logic               duty_vld_q, duty_vld_d;
    logic               no_signal_q, no_signal_d;

    logic [TMR_W-1:0]   timer_inc_s;
    logic [7:0]         swing_s;
    logic [7:0]         result_s;
    logic [ACC_W-1:0]   acc_sum_s;
    logic [7:0]         avg_s;

    // Datapath helpers: swing, clamped result, running sum and rounded average
    always_comb begin
        timer_inc_s = timer_q + TMR_ONE;
        swing_s     = (max_q >= min_q) ? (max_q - min_q) : 8'd0;
        result_s    = (bus.eng_duty > 8'd100) ? 8'd100 : bus.eng_duty;
        acc_sum_s   = acc_q + ACC_W'(result_s);
        avg_s       = 8'((acc_sum_s + ACC_HALF) >> AVG_LOG2);
    end

    // Next-state and next-output computation for the sequencer
    always_comb begin
        state_d     = state_q;
        max_d       = max_q;
        min_d       = min_q;
        scan_cnt_d  = scan_cnt_q;
        timer_d     = timer_q;
        res_cnt_d   = res_cnt_q;
        acc_d       = acc_q;
        eng_start_d = 1'b0;
        eng_high_d  = eng_high_q;
        eng_low_d   = eng_low_q;
        duty_d      = duty_q;
        duty_vld_d  = 1'b0;
        no_signal_d = no_signal_q;

        case (state_q)
            S_IDLE: begin
                max_d      = 8'd0;
                min_d      = 8'd255;
                scan_cnt_d = '0;
                res_cnt_d  = '0;
                acc_d      = '0;
                if (bus.enable) begin
                    state_d = S_SCAN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SCAN: begin
                if (!bus.enable) begin
                    state_d = S_IDLE;
                end else if (bus.sample_vld) begin
                    max_d = (bus.wave_in > max_q) ? bus.wave_in : max_q;
                    min_d = (bus.wave_in < min_q) ? bus.wave_in : min_q;
                    if (scan_cnt_q == SCAN_LAST) begin
                        scan_cnt_d = '0;
                        state_d    = S_CHECK;
                    end else begin
                        scan_cnt_d = scan_cnt_q + SCAN_ONE;
                    end
                end else begin
                    state_d = S_SCAN;
                end
            end
            S_CHECK: begin
                if (!bus.enable) begin
                    state_d = S_IDLE;
                end else if (swing_s < SWING_MIN) begin
                    no_signal_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    eng_high_d  = max_q;
                    eng_low_d   = min_q;
                    eng_start_d = 1'b1;
                    state_d     = S_START;
                end
            end
            S_START: begin
                timer_d = '0;
                if (!bus.enable) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                timer_d = timer_inc_s;
                if (!bus.enable) begin
                    state_d = S_IDLE;
                end else if (bus.eng_done) begin
                    // A result arriving on the timeout cycle still counts
                    acc_d     = acc_sum_s;
                    res_cnt_d = res_cnt_q + RES_ONE;
                    if (res_cnt_q == RES_LAST) begin
                        duty_d      = avg_s;
                        duty_vld_d  = 1'b1;
                        no_signal_d = 1'b0;
                        state_d     = S_OUTPUT;
                    end else begin
                        eng_start_d = 1'b1;
                        state_d     = S_START;
                    end
                end else if (timer_inc_s == TMR_LAST) begin
                    no_signal_d = 1'b1;
                    acc_d       = '0;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_OUTPUT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            max_q       <= 8'd0;
            min_q       <= 8'd255;
            scan_cnt_q  <= '0;
            timer_q     <= '0;
            res_cnt_q   <= '0;
            acc_q       <= '0;
            eng_start_q <= 1'b0;
            eng_high_q  <= 8'd0;
            eng_low_q   <= 8'd0;
            duty_q      <= 8'd0;
            duty_vld_q  <= 1'b0;
            no_signal_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            max_q       <= max_d;
            min_q       <= min_d;
            scan_cnt_q  <= scan_cnt_d;
            timer_q     <= timer_d;
            res_cnt_q   <= res_cnt_d;
            acc_q       <= acc_d;
            eng_start_q <= eng_start_d;
            eng_high_q  <= eng_high_d;
            eng_low_q   <= eng_low_d;
            duty_q      <= duty_d;
            duty_vld_q  <= duty_vld_d;
            no_signal_q <= no_signal_d;
        end
    end

    assign bus.eng_start = eng_start_q;
    assign bus.eng_high  = eng_high_q;
    assign bus.eng_low   = eng_low_q;
    assign bus.duty      = duty_q;
    assign bus.duty_vld  = duty_vld_q;
    assign bus.no_signal = no_signal_q;

endmodule

// File: tb/tb_duty_meas_ctrl.sv
// Directed bench for duty_meas_ctrl: square/constant stimulus, a small
// engine model with programmable latency and results, hand-computed expectations.
module tb_duty_meas_ctrl;

    localparam int EV_START = 0;
    localparam int EV_VLD   = 1;
    localparam int EV_NS    = 2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    duty_meas_if bus();

    duty_meas_ctrl #(
        .SCAN_LEN (64),
        .MIN_SWING(16),
        .TIMEOUT  (100),
        .AVG_LOG2 (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int n_start, n_vld, n_ns_rise;
    int start_cyc, first_start_cyc, vld_cyc, done_cyc, ns_rise_cyc, en_cyc;
    bit ns_prev = 1'b0;
    bit eng_auto = 1'b0;
    bit eng_busy = 1'b0;
    int eng_lat = 3;
    int eng_wait = 0;
    logic [7:0] resp [4];
    int resp_idx = 0;
    bit wave_const = 1'b0;
    int ph = 0;
    int vcount = 0;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // One clock: observe DUT outputs, run the engine model, drive next sample
    task automatic step();
        bit seen_start;
        @(posedge clk);
        #1;
        cyc++;
        seen_start = bus.eng_start;
        if (seen_start) begin
            if (n_start == 0) first_start_cyc = cyc;
            n_start++;
            start_cyc = cyc;
            if (eng_auto) begin
                eng_busy = 1'b1;
                eng_wait = eng_lat;
            end
        end
        if (bus.duty_vld) begin
            n_vld++;
            vld_cyc = cyc;
        end
        if (bus.no_signal && !ns_prev) begin
            n_ns_rise++;
            ns_rise_cyc = cyc;
        end
        ns_prev = bus.no_signal;
        bus.eng_done = 1'b0;
        if (eng_busy && !seen_start) begin
            eng_wait--;
            if (eng_wait == 0) begin
                bus.eng_done = 1'b1;
                bus.eng_duty = resp[resp_idx % 4];
                resp_idx++;
                eng_busy = 1'b0;
                done_cyc = cyc;
            end
        end
        if (ph % 2 == 0) begin
            bus.sample_vld = 1'b1;
            bus.wave_in = wave_const ? 8'd128 : ((vcount % 8 < 2) ? 8'd200 : 8'd0);
            vcount++;
        end else begin
            bus.sample_vld = 1'b0;
            bus.wave_in = wave_const ? 8'd0 : 8'd255;
        end
        ph++;
    endtask

    function automatic int cnt_of(input int which);
        case (which)
            EV_START: return n_start;
            EV_VLD:   return n_vld;
            default:  return n_ns_rise;
        endcase
    endfunction

    task automatic wait_evt(input string tag, input int which, input int target, input int budget);
        int k;
        k = 0;
        while (cnt_of(which) < target && k < budget) begin
            step();
            k++;
        end
        check_eq(tag, int'(cnt_of(which) >= target), 1);
    endtask

    task automatic reset_counts();
        n_start = 0;
        n_vld = 0;
        n_ns_rise = 0;
        eng_busy = 1'b0;
        resp_idx = 0;
    endtask

    task automatic load_resp(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d);
        resp[0] = a;
        resp[1] = b;
        resp[2] = c;
        resp[3] = d;
        resp_idx = 0;
    endtask

    task automatic go();
        bus.enable = 1'b1;
        ph = 0;
        vcount = 0;
        en_cyc = cyc;
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_eng_start"}, int'(bus.eng_start), 0);
        check_eq({pfx, "_eng_high"},  int'(bus.eng_high), 0);
        check_eq({pfx, "_eng_low"},   int'(bus.eng_low), 0);
        check_eq({pfx, "_duty"},      int'(bus.duty), 0);
        check_eq({pfx, "_duty_vld"},  int'(bus.duty_vld), 0);
        check_eq({pfx, "_no_signal"}, int'(bus.no_signal), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.enable = 1'b0;
        bus.wave_in = 8'd0;
        bus.sample_vld = 1'b0;
        bus.eng_done = 1'b0;
        bus.eng_duty = 8'd0;
        reset_counts();
        repeat (3) step();
        check_all_zero("rst");
        #2 rst_n = 1'b1;
        step();

        // Square 0/200, 25% high, results 25,25,26,26 -> (102+2)>>2 = 26
        reset_counts();
        wave_const = 1'b0;
        eng_auto = 1'b1;
        eng_lat = 3;
        load_resp(8'd25, 8'd25, 8'd26, 8'd26);
        go();
        wait_evt("sq_vld_wait", EV_VLD, 1, 2000);
        bus.enable = 1'b0;
        check_eq("sq_eng_high", int'(bus.eng_high), 200);
        check_eq("sq_eng_low", int'(bus.eng_low), 0);
        check_eq("sq_n_start", n_start, 4);
        check_eq("sq_duty", int'(bus.duty), 26);
        check_eq("sq_no_signal", int'(bus.no_signal), 0);
        check_eq("sq_first_start_lat", first_start_cyc - en_cyc, 129);
        check_eq("sq_vld_lat", vld_cyc - done_cyc, 1);
        repeat (20) step();
        check_eq("sq_duty_hold", int'(bus.duty), 26);
        check_eq("sq_n_vld", n_vld, 1);

        // Engine silent: abort exactly TIMEOUT cycles after eng_start
        reset_counts();
        eng_auto = 1'b0;
        go();
        wait_evt("to_start_wait", EV_START, 1, 400);
        wait_evt("to_ns_wait", EV_NS, 1, 200);
        bus.enable = 1'b0;
        check_eq("to_latency", ns_rise_cyc - start_cyc, 100);
        check_eq("to_no_signal", int'(bus.no_signal), 1);
        check_eq("to_n_vld", n_vld, 0);
        check_eq("to_duty_kept", int'(bus.duty), 26);
        check_eq("to_n_start", n_start, 1);
        repeat (10) step();

        // All results 255 clamp to 100
        reset_counts();
        eng_auto = 1'b1;
        eng_lat = 2;
        load_resp(8'd255, 8'd255, 8'd255, 8'd255);
        go();
        wait_evt("clamp_vld_wait", EV_VLD, 1, 1500);
        bus.enable = 1'b0;
        check_eq("clamp_duty", int'(bus.duty), 100);
        check_eq("clamp_no_signal", int'(bus.no_signal), 0);
        check_eq("clamp_n_start", n_start, 4);
        repeat (10) step();

        // Constant level: CHECK fails, then scan re-arms on its own
        reset_counts();
        wave_const = 1'b1;
        eng_auto = 1'b0;
        go();
        wait_evt("const_ns_wait", EV_NS, 1, 300);
        check_eq("const_ns_lat", ns_rise_cyc - en_cyc, 129);
        check_eq("const_n_start", n_start, 0);
        wave_const = 1'b0;
        wait_evt("const_rearm_start", EV_START, 1, 400);
        bus.enable = 1'b0;
        repeat (20) step();

        // Drop enable in WAIT after two results; late eng_done must be ignored
        reset_counts();
        eng_auto = 1'b1;
        eng_lat = 3;
        load_resp(8'd40, 8'd40, 8'd40, 8'd40);
        go();
        wait_evt("abort_start3_wait", EV_START, 3, 1000);
        step();
        bus.enable = 1'b0;
        repeat (200) step();
        check_eq("abort_n_start", n_start, 3);
        check_eq("abort_n_vld", n_vld, 0);
        check_eq("abort_duty_kept", int'(bus.duty), 100);
        check_eq("abort_eng_high_kept", int'(bus.eng_high), 200);
        // Fresh run: 10+20+30+40 = 100, (100+2)>>2 = 25
        reset_counts();
        load_resp(8'd10, 8'd20, 8'd30, 8'd40);
        go();
        wait_evt("fresh_vld_wait", EV_VLD, 1, 1500);
        bus.enable = 1'b0;
        check_eq("fresh_duty", int'(bus.duty), 25);
        check_eq("fresh_n_start", n_start, 4);
        check_eq("fresh_no_signal", int'(bus.no_signal), 0);
        repeat (10) step();

        // eng_done on the timeout cycle is accepted every time
        reset_counts();
        eng_lat = 99;
        load_resp(8'd50, 8'd50, 8'd50, 8'd50);
        go();
        wait_evt("edge_vld_wait", EV_VLD, 1, 1200);
        bus.enable = 1'b0;
        check_eq("edge_duty", int'(bus.duty), 50);
        check_eq("edge_ns_rises", n_ns_rise, 0);
        check_eq("edge_no_signal", int'(bus.no_signal), 0);
        check_eq("edge_n_start", n_start, 4);
        repeat (10) step();

        // Asynchronous reset mid-SCAN clears outputs immediately
        reset_counts();
        go();
        repeat (40) step();
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        bus.enable = 1'b0;
        #2 rst_n = 1'b1;
        repeat (5) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
